// File: rtl/hazard_ctrl_if.sv
// ID-stage control bundle in, hazard/forwarding controls out, for hazard_ctrl.
// Combinational outputs settle in the same cycle; there is no backpressure beyond freeze.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             id_uses_rs2;
  logic [2:0]       id_memCtrl;
  logic [1:0]       id_wbCtrl;
  logic             br_taken;
  logic             dmem_ready;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_flush;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;

  modport master (
    output id_inst, id_valid, id_uses_rs2, id_memCtrl, id_wbCtrl, br_taken, dmem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_flush, freeze,
    input  fwd_a, fwd_b, stall_cnt, mem_err
  );

  modport slave (
    input  id_inst, id_valid, id_uses_rs2, id_memCtrl, id_wbCtrl, br_taken, dmem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_flush, freeze,
    output fwd_a, fwd_b, stall_cnt, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: shadow EX/MEM/WB scoreboard, stalls, flushes, forwarding.
// Hold/flush/forward outputs are combinational from scoreboard + ID; dmem wait freezes everything.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwrite;
    logic       memread;
    logic       memacc;
  } ex_slot_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memacc;
  } mem_slot_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
  } wb_slot_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_ERR     = 2'd2
  } state_t;

  ex_slot_t         r_ex;
  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_err;

  logic [4:0]       w_id_rs1;
  logic [4:0]       w_id_rs2;
  logic [4:0]       w_id_rd;
  ex_slot_t         w_id_slot;
  logic             w_ldu;
  logic             w_wait;
  logic             w_freeze;
  logic             w_pc_hold;
  logic             w_ifid_hold;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_exmem_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_unused;

  assign w_id_rs1 = hz.id_inst[19:15];
  assign w_id_rs2 = hz.id_inst[24:20];
  assign w_id_rd  = hz.id_inst[11:7];

  // Opcode/funct bits, Branch and MemtoReg are carried by the pipeline itself, not needed here.
  assign w_unused = &{1'b0, hz.id_inst[31:25], hz.id_inst[14:12], hz.id_inst[6:0],
                      hz.id_memCtrl[0], hz.id_wbCtrl[1]};

  assign w_ldu = r_ex.memread && (r_ex.rd != 5'd0) && hz.id_valid &&
                 ((r_ex.rd == w_id_rs1) || (hz.id_uses_rs2 && (r_ex.rd == w_id_rs2)));

  assign w_wait = r_mem.memacc && !hz.dmem_ready && (r_state != S_ERR);

  always_comb begin
    w_state_nxt   = r_state;
    w_freeze      = 1'b0;
    w_pc_hold     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_flush = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_wait) begin
          w_state_nxt = S_MEMWAIT;
        end
      end
      S_MEMWAIT: begin
        if (hz.dmem_ready) begin
          w_state_nxt = S_RUN;
        end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (!reset) begin
      if (w_wait || (r_state == S_ERR)) begin
        w_freeze    = 1'b1;
        w_pc_hold   = 1'b1;
        w_ifid_hold = 1'b1;
      end else if (hz.br_taken) begin
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_exmem_flush = 1'b1;
      end else if (w_ldu) begin
        w_pc_hold     = 1'b1;
        w_ifid_hold   = 1'b1;
        w_idex_bubble = 1'b1;
      end
    end
  end

  // Forwarding: the younger MEM result wins over WB for the same register.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_mem.regwrite && (r_mem.rd != 5'd0) && (r_mem.rd == r_ex.rs1)) begin
      w_fwd_a = 2'b10;
    end else if (r_wb.regwrite && (r_wb.rd != 5'd0) && (r_wb.rd == r_ex.rs1)) begin
      w_fwd_a = 2'b01;
    end
    if (r_mem.regwrite && (r_mem.rd != 5'd0) && (r_mem.rd == r_ex.rs2)) begin
      w_fwd_b = 2'b10;
    end else if (r_wb.regwrite && (r_wb.rd != 5'd0) && (r_wb.rd == r_ex.rs2)) begin
      w_fwd_b = 2'b01;
    end
  end

  always_comb begin
    w_id_slot = '0;
    if (hz.id_valid && !w_idex_bubble) begin
      w_id_slot.rd       = w_id_rd;
      w_id_slot.rs1      = w_id_rs1;
      w_id_slot.rs2      = w_id_rs2;
      w_id_slot.regwrite = hz.id_wbCtrl[0];
      w_id_slot.memread  = hz.id_memCtrl[2];
      w_id_slot.memacc   = hz.id_memCtrl[2] | hz.id_memCtrl[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (!w_freeze) begin
        r_wb.rd       <= r_mem.rd;
        r_wb.regwrite <= r_mem.regwrite;
        if (w_exmem_flush) begin
          r_mem <= '0;
        end else begin
          r_mem.rd       <= r_ex.rd;
          r_mem.regwrite <= r_ex.regwrite;
          r_mem.memacc   <= r_ex.memacc;
        end
        r_ex <= w_id_slot;
      end

      if ((r_state == S_MEMWAIT) && (w_state_nxt == S_MEMWAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (w_state_nxt == S_ERR) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign hz.pc_hold     = w_pc_hold;
  assign hz.ifid_hold   = w_ifid_hold;
  assign hz.ifid_flush  = w_ifid_flush;
  assign hz.idex_bubble = w_idex_bubble;
  assign hz.exmem_flush = w_exmem_flush;
  assign hz.freeze      = w_freeze;
  assign hz.fwd_a       = w_fwd_a;
  assign hz.fwd_b       = w_fwd_b;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.mem_err     = r_mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding priority, x0, branch flush, mem wait, timeout.
module tb_hazard_ctrl;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic [CNT_W-1:0] s_base;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic set_id(input logic v, input logic [31:0] inst, input logic u2,
                        input logic [2:0] mc, input logic [1:0] wc);
    hz.id_valid    = v;
    hz.id_inst     = inst;
    hz.id_uses_rs2 = u2;
    hz.id_memCtrl  = mc;
    hz.id_wbCtrl   = wc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ctl_outs();
    return {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_bubble, hz.exmem_flush,
            hz.freeze, hz.fwd_a, hz.fwd_b};
  endfunction

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    hz.br_taken   = 1'b0;
    hz.dmem_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_ctl", ctl_outs(), 10'd0);
    check_eq("rst_stall_cnt", hz.stall_cnt, 0);
    check_eq("rst_mem_err", hz.mem_err, 0);

    // lw x5 -> add x6,x5,x1
    set_id(1'b1, r_type(5'd5, 5'd1, 5'd0), 1'b0, 3'b100, 2'b11);
    #1;
    check_eq("lw_no_stall", hz.pc_hold, 0);
    tick();
    set_id(1'b1, r_type(5'd6, 5'd5, 5'd1), 1'b1, 3'b000, 2'b01);
    #1;
    check_eq("ldu_hold", {hz.pc_hold, hz.ifid_hold, hz.idex_bubble,
                          hz.ifid_flush, hz.exmem_flush, hz.freeze}, 6'b111000);
    tick();
    check_eq("ldu_one_cycle", {hz.pc_hold, hz.ifid_hold, hz.idex_bubble}, 3'b000);
    check_eq("ldu_stall_cnt", hz.stall_cnt, 1);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    #1;
    check_eq("fwd_wb_a", hz.fwd_a, 2'b01);
    check_eq("fwd_wb_b", hz.fwd_b, 2'b00);

    // add x5 ; add x5 ; sub x7,x5,x5 -> MEM beats WB
    tick();
    set_id(1'b1, r_type(5'd5, 5'd1, 5'd2), 1'b1, 3'b000, 2'b01);
    tick();
    set_id(1'b1, r_type(5'd5, 5'd3, 5'd4), 1'b1, 3'b000, 2'b01);
    tick();
    set_id(1'b1, r_type(5'd7, 5'd5, 5'd5), 1'b1, 3'b000, 2'b01);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    #1;
    check_eq("fwd_mem_prio_a", hz.fwd_a, 2'b10);
    check_eq("fwd_mem_prio_b", hz.fwd_b, 2'b10);

    // lw x0 ; add x6,x0,x0 -> no stall, no forwarding
    tick();
    set_id(1'b1, r_type(5'd0, 5'd1, 5'd0), 1'b0, 3'b100, 2'b11);
    tick();
    set_id(1'b1, r_type(5'd6, 5'd0, 5'd0), 1'b1, 3'b000, 2'b01);
    #1;
    check_eq("x0_no_stall", {hz.pc_hold, hz.idex_bubble}, 2'b00);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    #1;
    check_eq("x0_fwd", {hz.fwd_a, hz.fwd_b}, 4'b0000);

    // taken branch squashes a simultaneous load-use stall
    s_base = hz.stall_cnt;
    tick();
    set_id(1'b1, r_type(5'd9, 5'd1, 5'd0), 1'b0, 3'b100, 2'b11);
    tick();
    set_id(1'b1, r_type(5'd10, 5'd9, 5'd9), 1'b1, 3'b000, 2'b01);
    hz.br_taken = 1'b1;
    #1;
    check_eq("br_flush", {hz.ifid_flush, hz.idex_bubble, hz.exmem_flush}, 3'b111);
    check_eq("br_no_hold", {hz.pc_hold, hz.ifid_hold, hz.freeze}, 3'b000);
    tick();
    hz.br_taken = 1'b0;
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    hz.dmem_ready = 1'b0;
    #1;
    check_eq("br_stall_cnt", hz.stall_cnt, s_base);
    check_eq("br_mem_cleared", hz.freeze, 0);
    hz.dmem_ready = 1'b1;

    // lw x11 in MEM, dmem_ready low three cycles
    tick();
    set_id(1'b1, r_type(5'd11, 5'd2, 5'd0), 1'b0, 3'b100, 2'b11);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    tick();
    set_id(1'b1, r_type(5'd12, 5'd11, 5'd11), 1'b1, 3'b000, 2'b01);
    hz.dmem_ready = 1'b0;
    #1;
    s_base = hz.stall_cnt;
    for (int i = 0; i < 3; i++) begin
      check_eq("wait_freeze", {hz.freeze, hz.pc_hold, hz.ifid_hold,
                               hz.idex_bubble, hz.ifid_flush, hz.exmem_flush}, 6'b111000);
      tick();
    end
    hz.dmem_ready = 1'b1;
    #1;
    check_eq("wait_release", hz.freeze, 0);
    check_eq("wait_stall_cnt", hz.stall_cnt, 32'(s_base) + 32'd3);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    #1;
    check_eq("wait_slots_held", {hz.fwd_a, hz.fwd_b}, 4'b0101);

    // store that never completes -> timeout
    set_id(1'b1, r_type(5'd0, 5'd2, 5'd3), 1'b1, 3'b010, 2'b00);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    tick();
    hz.dmem_ready = 1'b0;
    #1;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
    end
    check_eq("pre_timeout", {hz.freeze, hz.mem_err}, 2'b10);
    tick();
    check_eq("timeout_err", hz.mem_err, 1);
    hz.dmem_ready = 1'b1;
    #1;
    check_eq("err_freeze", hz.freeze, 1);
    tick();
    tick();
    check_eq("err_sticky", {hz.freeze, hz.mem_err, hz.pc_hold}, 3'b111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_ctl", ctl_outs(), 10'd0);
    check_eq("post_rst_cnt", {16'(hz.stall_cnt), 15'd0, hz.mem_err}, 32'd0);

    // reset while waiting on memory
    set_id(1'b1, r_type(5'd0, 5'd2, 5'd3), 1'b1, 3'b010, 2'b00);
    tick();
    set_id(1'b0, 32'd0, 1'b0, 3'b000, 2'b00);
    tick();
    hz.dmem_ready = 1'b0;
    tick();
    tick();
    check_eq("midwait_freeze", hz.freeze, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("midwait_rst", {hz.freeze, hz.pc_hold, hz.mem_err}, 3'b000);
    check_eq("midwait_rst_cnt", hz.stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
